// File: rtl/decode_stage.sv
// RISC-V decode stage: registered decode bundle behind a
// two-entry skid buffer, with flush and illegal counting.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  pc_out,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm_ext,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [1:0]      alu_op;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam bit M_ON = (ENABLE_M != 0);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rd_f  = instr[11:7];
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_u;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  logic r_ok;
  logic ilog_bad;
  logic ld_bad;
  logic st_bad;
  logic br_bad;

  assign r_ok = (f7 == 7'b0000000)
              || (f7 == 7'b0100000
                  && (f3 == 3'b000 || f3 == 3'b101))
              || (f7 == 7'b0000001 && M_ON);

  // RV64 shift encodings use a 6-bit shamt, so only RV32 is
  // restricted on the upper immediate bits.
  assign ilog_bad = !RV64
    && ((f3 == 3'b001 && f7 != 7'b0000000)
        || (f3 == 3'b101 && f7 != 7'b0000000
            && f7 != 7'b0100000));

  assign ld_bad = (f3 == 3'b111)
    || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));

  assign st_bad = RV64 ? (f3 > 3'b011) : (f3 > 3'b010);

  assign br_bad = (f3 == 3'b010) || (f3 == 3'b011);

  bundle_t dec;
  logic    bad;

  // Combinational field decode of the incoming instruction.
  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.pc     = pc_in;
    dec.opcode = op;
    dec.alu_op = 2'b11;
    unique case (1'b1)
      op == OP_R: begin
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.rd     = rd_f;
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        dec.alu_op = 2'b10;
        bad        = !r_ok;
      end
      op == OP_I: begin
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.rd     = rd_f;
        dec.rs1    = rs1_f;
        dec.imm    = XLEN'(imm_i);
        dec.alu_op = 2'b10;
        bad        = ilog_bad;
      end
      op == OP_LD: begin
        dec.funct3 = f3;
        dec.rd     = rd_f;
        dec.rs1    = rs1_f;
        dec.imm    = XLEN'(imm_i);
        dec.alu_op = 2'b00;
        bad        = ld_bad;
      end
      op == OP_ST: begin
        dec.funct3 = f3;
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        dec.imm    = XLEN'(imm_s);
        dec.alu_op = 2'b00;
        bad        = st_bad;
      end
      op == OP_BR: begin
        dec.funct3 = f3;
        dec.rs1    = rs1_f;
        dec.rs2    = rs2_f;
        dec.imm    = XLEN'(imm_b);
        dec.alu_op = 2'b01;
        bad        = br_bad;
      end
      op == OP_JAL: begin
        dec.rd     = rd_f;
        dec.imm    = XLEN'(imm_j);
      end
      op == OP_JALR: begin
        dec.funct3 = f3;
        dec.rd     = rd_f;
        dec.rs1    = rs1_f;
        dec.imm    = XLEN'(imm_i);
        dec.alu_op = 2'b00;
        bad        = (f3 != 3'b000);
      end
      op == OP_LUI,
      op == OP_AUIPC: begin
        dec.rd     = rd_f;
        dec.imm    = XLEN'(imm_u);
        dec.alu_op = 2'b00;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    if (bad) dec.alu_op = 2'b11;
    dec.illegal = bad;
  end

  state_t  state_q;
  state_t  state_d;
  bundle_t a_q;
  bundle_t b_q;
  logic    in_ready_q;
  logic    accept;
  logic    present;
  logic    load_a;
  logic    load_b;
  logic    shift;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q && !flush;
  assign present   = out_valid && out_ready;

  // Skid buffer occupancy and entry load selects.
  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    shift   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            load_a  = 1'b1;
          end
        end
        ONE: begin
          if (accept && !present) begin
            state_d = TWO;
            load_b  = 1'b1;
          end else if (accept) begin
            load_a  = 1'b1;
          end else if (present) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (present) begin
            state_d = ONE;
            shift   = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready looks ahead at the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Output entry A and skid entry B.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (load_a) a_q <= dec;
      else if (shift) a_q <= b_q;
      if (load_b) b_q <= dec;
    end
  end

  logic [CNT_W-1:0] cnt_q;

  // Saturating count of accepted illegal instructions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept && dec.illegal
                 && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign pc_out        = a_q.pc;
  assign opcode        = a_q.opcode;
  assign funct3        = a_q.funct3;
  assign funct7        = a_q.funct7;
  assign rd            = a_q.rd;
  assign rs1           = a_q.rs1;
  assign rs2           = a_q.rs2;
  assign imm_ext       = a_q.imm;
  assign alu_op        = a_q.alu_op;
  assign illegal       = a_q.illegal;
  assign illegal_count = cnt_q;

endmodule
